// File: rtl/cpu_frame_ctrl.sv
// Frame sequencer: boots the cpu, copies the render list into the shadow buffer once the cpu
// parks on WAIT, then releases the cpu on the next vsync edge and flags missed frames.
module cpu_frame_ctrl #(
  parameter int                    DATA_WIDTH  = 13,
  parameter int                    BOOT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] COPY_BASE   = 13'h000,
  parameter int                    COPY_LEN    = 384,
  localparam int                   CNT_W       = $clog2(COPY_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  vsync,
  input  logic                  cpu_waiting,
  output logic                  cpu_reset,
  output logic                  cpu_resume,
  output logic                  mem_sel,
  output logic [DATA_WIDTH-1:0] copy_addr,
  input  logic [15:0]           mem_rdata,
  output logic                  buf_we,
  output logic [CNT_W-1:0]      buf_waddr,
  output logic [15:0]           buf_wdata,
  output logic                  frame_ready,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam int                BOOT_W    = $clog2(BOOT_CYCLES + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COPY_END  = CNT_W'(COPY_LEN);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(COPY_LEN - 1);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    COPY,
    IDLE,
    RESUME
  } state_t;

  state_t            state_reg, state_next;
  logic [BOOT_W-1:0] boot_cnt_reg, boot_cnt_next;
  logic [CNT_W-1:0]  copy_cnt_reg, copy_cnt_next;
  logic              vsync_q_reg;
  logic              overrun_reg, overrun_next;
  logic [15:0]       frame_count_reg, frame_count_next;
  logic              idle_first_reg, idle_first_next;
  logic              vsync_edge;

  assign vsync_edge  = vsync & ~vsync_q_reg;
  assign overrun     = overrun_reg;
  assign frame_count = frame_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= BOOT;
      boot_cnt_reg    <= '0;
      copy_cnt_reg    <= '0;
      vsync_q_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      frame_count_reg <= '0;
      idle_first_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      boot_cnt_reg    <= boot_cnt_next;
      copy_cnt_reg    <= copy_cnt_next;
      vsync_q_reg     <= restart ? 1'b0 : vsync;
      overrun_reg     <= overrun_next;
      frame_count_reg <= frame_count_next;
      idle_first_reg  <= idle_first_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    boot_cnt_next    = boot_cnt_reg;
    copy_cnt_next    = copy_cnt_reg;
    overrun_next     = overrun_reg;
    frame_count_next = frame_count_reg;
    idle_first_next  = 1'b0;

    case (state_reg)
      BOOT: begin
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next    = RUN;
          boot_cnt_next = '0;
        end else begin
          boot_cnt_next = boot_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (vsync_edge) overrun_next = 1'b1;
        if (cpu_waiting) begin
          state_next    = COPY;
          copy_cnt_next = '0;
        end
      end
      COPY: begin
        if (vsync_edge) overrun_next = 1'b1;
        // Count runs one past the last address so the final read can land in the buffer.
        if (copy_cnt_reg == COPY_END) begin
          state_next      = IDLE;
          copy_cnt_next   = '0;
          idle_first_next = 1'b1;
        end else begin
          copy_cnt_next = copy_cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        if (vsync_edge) state_next = RESUME;
      end
      RESUME: begin
        if (vsync_edge) overrun_next = 1'b1;
        frame_count_next = frame_count_reg + 1'b1;
        state_next       = RUN;
      end
      default: state_next = BOOT;
    endcase

    if (restart) begin
      state_next       = BOOT;
      boot_cnt_next    = '0;
      copy_cnt_next    = '0;
      overrun_next     = 1'b0;
      frame_count_next = '0;
      idle_first_next  = 1'b0;
    end

    cpu_reset   = (state_reg == BOOT);
    cpu_resume  = (state_reg == RESUME);
    mem_sel     = (state_reg == COPY);
    frame_ready = (state_reg == IDLE) && idle_first_reg;
    buf_we      = (state_reg == COPY) && (copy_cnt_reg != '0);
    buf_waddr   = buf_we ? (copy_cnt_reg - CNT_W'(1)) : '0;
    buf_wdata   = buf_we ? mem_rdata : '0;
    copy_addr   = '0;
    if (state_reg == COPY) begin
      copy_addr = COPY_BASE +
                  DATA_WIDTH'((copy_cnt_reg == COPY_END) ? LAST_IDX : copy_cnt_reg);
    end
  end

endmodule

// File: tb/tb_cpu_frame_ctrl.sv
// Directed-random bench for cpu_frame_ctrl: frame-level reference model with a 1-cycle memory.
module tb_cpu_frame_ctrl;

  localparam int          DW = 13;
  localparam int          BC = 4;
  localparam int          CL = 4;
  localparam logic [12:0] CB = 13'h100;
  localparam int          CW = $clog2(CL + 1);

  logic          clk, reset, restart, vsync, cpu_waiting;
  logic          cpu_reset, cpu_resume, mem_sel, buf_we, frame_ready, overrun;
  logic [DW-1:0] copy_addr;
  logic [15:0]   mem_rdata, buf_wdata, frame_count;
  logic [CW-1:0] buf_waddr;
  logic [15:0]   mem [0:(1<<DW)-1];

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  bit exp_overrun = 1'b0;

  cpu_frame_ctrl #(
    .DATA_WIDTH(DW), .BOOT_CYCLES(BC), .COPY_BASE(CB), .COPY_LEN(CL)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .vsync(vsync),
    .cpu_waiting(cpu_waiting), .cpu_reset(cpu_reset), .cpu_resume(cpu_resume),
    .mem_sel(mem_sel), .copy_addr(copy_addr), .mem_rdata(mem_rdata),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .frame_ready(frame_ready), .overrun(overrun), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[copy_addr];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic boot_check();
    int n = 0;
    int noise = 0;
    while (cpu_reset === 1'b1 && n < 20) begin
      n++;
      if (frame_ready !== 1'b0 || mem_sel !== 1'b0 || cpu_resume !== 1'b0) noise++;
      tick();
    end
    check("boot_len", n, BC);
    check("boot_quiet", noise, 0);
    $display("boot: cpu_reset held %0d cycles", n);
  endtask

  task automatic run_phase(input int cycles, input bit with_vsync);
    for (int i = 0; i < cycles; i++) begin
      check("run_outputs", {cpu_reset, mem_sel, cpu_resume}, 3'b000);
      tick();
    end
    if (with_vsync) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      exp_overrun = 1'b1;
      check("no_resume_on_overrun", cpu_resume, 1'b0);
      tick();
      check("overrun_set", overrun, exp_overrun);
    end
  endtask

  task automatic copy_phase();
    int sel = 0;
    int wr = 0;
    int c = 0;
    int last_wr = -1;
    int fr_cyc = -1;
    for (int i = 0; i < CL; i++) mem[int'(CB) + i] = 16'($urandom);
    cpu_waiting = 1'b1;
    while (fr_cyc < 0 && c < CL + 6) begin
      tick();
      c++;
      if (mem_sel) begin
        check("copy_addr", copy_addr, int'(CB) + ((sel < CL) ? sel : CL - 1));
        sel++;
      end
      if (buf_we) begin
        check("buf_waddr", buf_waddr, wr);
        check("buf_wdata", buf_wdata, mem[int'(CB) + wr]);
        wr++;
        last_wr = c;
      end
      if (frame_ready) fr_cyc = c;
    end
    check("copy_sel_cycles", sel, CL + 1);
    check("copy_writes", wr, CL);
    check("frame_ready_at", fr_cyc, last_wr + 1);
    $display("copy: sel=%0d writes=%0d frame_ready_cycle=%0d", sel, wr, fr_cyc);
  endtask

  task automatic resume_phase(input int idle_wait);
    for (int i = 0; i < idle_wait; i++) begin
      tick();
      check("idle_hold", {cpu_resume, frame_ready, mem_sel}, 3'b000);
    end
    vsync = 1'b1;
    tick();
    check("resume_pulse", cpu_resume, 1'b1);
    check("count_before_resume", frame_count, exp_count);
    tick();
    cpu_waiting = 1'b0;
    vsync = 1'b0;
    exp_count = (exp_count + 1) & 16'hFFFF;
    check("resume_one_cycle", cpu_resume, 1'b0);
    check("frame_count", frame_count, exp_count);
    check("no_recopy", mem_sel, 1'b0);
    tick();
    check("no_recopy_run", mem_sel, 1'b0);
    check("overrun_level", overrun, exp_overrun);
    $display("resume: idle_wait=%0d frame_count=%0d overrun=%0b", idle_wait, frame_count, overrun);
  endtask

  initial begin
    reset = 1'b0;
    restart = 1'b0;
    vsync = 1'b0;
    cpu_waiting = 1'b0;
    for (int i = 0; i < (1 << DW); i++) mem[i] = 16'($urandom);

    tick();
    tick();
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_flags", {cpu_resume, mem_sel, buf_we, frame_ready, overrun}, 5'b0);
    check("rst_frame_count", frame_count, 16'h0);
    check("rst_copy_addr", copy_addr, 13'h0);
    check("rst_buf", {buf_waddr, buf_wdata}, '0);

    reset = 1'b1;
    boot_check();
    check("run_after_boot", {cpu_reset, mem_sel, cpu_resume, overrun}, 4'b0);

    // Clean frame; vsync lands in the first IDLE cycle.
    run_phase(2, 1'b0);
    copy_phase();
    resume_phase(0);

    // Missed frame: vsync while the cpu is still running.
    run_phase(1, 1'b1);
    copy_phase();
    check("overrun_after_copy", overrun, 1'b1);
    resume_phase(1);

    for (int f = 0; f < 4; f++) begin
      run_phase($urandom_range(0, 4), 1'($urandom_range(0, 1)));
      copy_phase();
      resume_phase($urandom_range(0, 3));
    end

    // Restart in copy cycle 2 abandons the copy.
    run_phase(1, 1'b0);
    cpu_waiting = 1'b1;
    tick();
    tick();
    tick();
    check("copy_active_before_restart", mem_sel, 1'b1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    cpu_waiting = 1'b0;
    exp_count = 0;
    exp_overrun = 1'b0;
    check("restart_cpu_reset", cpu_reset, 1'b1);
    check("restart_flags", {mem_sel, buf_we, overrun, frame_ready, cpu_resume}, 5'b0);
    check("restart_frame_count", frame_count, 16'h0);
    boot_check();

    run_phase(1, 1'b0);
    copy_phase();
    resume_phase(0);

    // Asynchronous reset mid-copy must act without a clock edge.
    run_phase(1, 1'b0);
    cpu_waiting = 1'b1;
    tick();
    tick();
    check("copy_active_before_reset", mem_sel, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_cpu_reset", cpu_reset, 1'b1);
    check("async_mem_sel", mem_sel, 1'b0);
    check("async_buf_we", buf_we, 1'b0);
    check("async_frame_count", frame_count, 16'h0);
    $display("async reset: cpu_reset=%0b mem_sel=%0b", cpu_reset, mem_sel);
    cpu_waiting = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
